// File: rtl/cmult_acc.sv
// Small generic FIFO; registered storage, combinational head. Push into a full FIFO succeeds
// only when a pop happens on the same edge. Otherwise the push is ignored.
module fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] pop_dat,
  output logic         empty,
  output logic         full
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

// Sums LEN complex samples per frame and saturates each component to N bits. The result is
// buffered one cycle after the last sample in a 2-deep FIFO. A result arriving while the FIFO is full is dropped and err_drop is set.
module cmult_acc #(
  parameter int N   = 32,
  parameter int Q   = 22,
  parameter int LEN = 16,
  parameter int G   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     in_valid,
  input  logic [N-1:0]             in_re,
  input  logic [N-1:0]             in_im,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             out_re,
  output logic [N-1:0]             out_im,
  output logic                     out_sat,
  output logic                     err_drop,
  output logic [$clog2(LEN)-1:0]   frame_pos
);
  localparam int              PW       = $clog2(LEN);
  localparam int              AW       = N + G;
  localparam logic [PW-1:0]   LAST_POS = PW'(LEN - 1);

  if (G < $clog2(LEN)) begin : g_guard_check
    $error("cmult_acc: G must be at least clog2(LEN)");
  end
  if (LEN < 2 || LEN > 1024) begin : g_len_check
    $error("cmult_acc: LEN must be in 2..1024");
  end
  if (Q < 0 || Q >= N) begin : g_q_check
    $error("cmult_acc: Q must be in 0..N-1");
  end

  logic signed [AW-1:0] acc_re, acc_im;
  logic signed [AW-1:0] ext_re, ext_im;
  logic signed [AW-1:0] sum_re, sum_im;
  logic [N:0]           sat_re, sat_im;
  logic                 last;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [2*N:0]         push_dat;
  logic [2*N:0]         pop_dat;

  // Returns {saturated, value}; the sum fits in N bits only if the top G+1 bits agree.
  function automatic logic [N:0] saturate(input logic signed [AW-1:0] s);
    logic [N:0] r;
    if (s[AW-1:N-1] == '0 || s[AW-1:N-1] == '1) r = {1'b0, s[N-1:0]};
    else if (s[AW-1])                           r = {1'b1, 1'b1, {(N-1){1'b0}}};
    else                                        r = {1'b1, 1'b0, {(N-1){1'b1}}};
    return r;
  endfunction

  assign ext_re = {{G{in_re[N-1]}}, in_re};
  assign ext_im = {{G{in_im[N-1]}}, in_im};
  assign sum_re = ((frame_pos == '0) ? '0 : acc_re) + ext_re;
  assign sum_im = ((frame_pos == '0) ? '0 : acc_im) + ext_im;
  assign sat_re = saturate(sum_re);
  assign sat_im = saturate(sum_im);

  assign last     = (frame_pos == LAST_POS);
  assign push     = in_valid && last && !clr;
  assign pop      = out_valid && out_ready;
  assign push_dat = {sat_re[N-1:0], sat_im[N-1:0], sat_re[N] | sat_im[N]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_pos <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
    end else if (clr) begin
      frame_pos <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
    end else if (in_valid) begin
      frame_pos <= last ? '0 : frame_pos + PW'(1);
      // The final sample goes straight to the FIFO; the next frame reloads the accumulators.
      if (!last) begin
        acc_re <= sum_re;
        acc_im <= sum_im;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                err_drop <= 1'b0;
    else if (clr)                           err_drop <= 1'b0;
    else if (push && fifo_full && !pop)     err_drop <= 1'b1;
  end

  fifo #(.W(2*N+1), .DEPTH(2)) u_out_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .push     (push),
    .push_dat (push_dat),
    .pop      (pop),
    .pop_dat  (pop_dat),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign out_valid = !fifo_empty;
  assign out_re    = pop_dat[2*N:N+1];
  assign out_im    = pop_dat[N:1];
  assign out_sat   = pop_dat[0];
endmodule

// File: tb/tb_cmult_acc.sv
// Scoreboard bench for cmult_acc with LEN=4: frame results are modelled as stimulus is driven
// and compared when the DUT presents them.
module tb_cmult_acc;
  localparam int N = 32, Q = 22, LEN = 4, G = 4;
  localparam longint MAXV = (longint'(1) <<< (N-1)) - 1;
  localparam longint MINV = -(longint'(1) <<< (N-1));

  typedef struct packed {
    logic [N-1:0] re;
    logic [N-1:0] im;
    logic         sat;
  } res_t;
  typedef logic [N-1:0] frame_t [LEN];

  logic         clk = 1'b0;
  logic         rst, clr, in_valid, out_ready;
  logic [N-1:0] in_re, in_im;
  logic         out_valid, out_sat, err_drop;
  logic [N-1:0] out_re, out_im;
  logic [1:0]   frame_pos;

  int     checks = 0;
  int     failures = 0;
  res_t   exp_q[$];
  res_t   got;
  frame_t cur_re, cur_im;

  cmult_acc #(.N(N), .Q(Q), .LEN(LEN), .G(G)) dut (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
    .out_valid(out_valid), .out_ready(out_ready), .out_re(out_re), .out_im(out_im),
    .out_sat(out_sat), .err_drop(err_drop), .frame_pos(frame_pos)
  );

  always #5 clk = ~clk;

  function automatic logic [N:0] sat_model(input longint s);
    longint     c;
    logic [63:0] b;
    c = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
    b = c;
    return {(s > MAXV) || (s < MINV), b[N-1:0]};
  endfunction

  task automatic set_const(input logic [N-1:0] re, input logic [N-1:0] im);
    for (int i = 0; i < LEN; i++) begin
      cur_re[i] = re;
      cur_im[i] = im;
    end
  endtask

  // Drives cur_re/cur_im as one frame; ends at the negedge after the last sample edge.
  task automatic send_frame(input bit keep, input bit ready_at_last);
    longint     sr = 0, si = 0;
    logic [N:0] r;
    res_t       e;
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_re    = cur_re[i];
      in_im    = cur_im[i];
      if (ready_at_last && i == LEN-1) out_ready = 1'b1;
      sr += longint'(signed'(cur_re[i]));
      si += longint'(signed'(cur_im[i]));
    end
    r = sat_model(sr);
    e.re = r[N-1:0];
    e.sat = r[N];
    r = sat_model(si);
    e.im = r[N-1:0];
    e.sat = e.sat | r[N];
    @(negedge clk);
    in_valid = 1'b0;
    if (ready_at_last) begin
      out_ready = 1'b0;
      void'(exp_q.pop_front());
    end
    if (keep) exp_q.push_back(e);
  endtask

  task automatic test_reset;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_re = '0; in_im = '0;
    @(negedge clk);
    got = {out_re, out_im, out_sat};
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (frame_pos !== 2'd0) begin failures++; $display("FAIL reset_frame_pos got=%0d exp=0", frame_pos); end
    checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL reset_err_drop got=%b exp=0", err_drop); end
    checks++; if (got !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", got); end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    out_ready = 1'b1;
    set_const(32'h00400000, 32'hFFE00000);
    send_frame(1'b1, 1'b0);
    got = {out_re, out_im, out_sat};
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", out_valid); end
    checks++; if (got !== {32'h01000000, 32'hFF800000, 1'b0}) begin failures++; $display("FAIL basic_const got=%h exp=%h", got, {32'h01000000, 32'hFF800000, 1'b0}); end
    checks++; if (got !== exp_q[0]) begin failures++; $display("FAIL basic_model got=%h exp=%h", got, exp_q[0]); end
    checks++; if (frame_pos !== 2'd0) begin failures++; $display("FAIL basic_frame_pos got=%0d exp=0", frame_pos); end
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_popped got=%b exp=0", out_valid); end
    out_ready = 1'b0;
  endtask

  task automatic test_saturation;
    out_ready = 1'b1;
    for (int f = 0; f < 3; f++) begin
      if (f == 0) set_const(32'h7FFFFFFF, 32'h80000000);
      if (f == 1) set_const(32'h30000000, 32'h00000001);
      if (f == 2) begin
        set_const(32'h20000000, 32'hE0000000);
        cur_re[3] = 32'h1FFFFFFF;
      end
      send_frame(1'b1, 1'b0);
      got = {out_re, out_im, out_sat};
      checks++; if (out_valid !== 1'b1 || got !== exp_q[0]) begin failures++; $display("FAIL sat_frame%0d got=%h valid=%b exp=%h", f, got, out_valid, exp_q[0]); end
      if (f == 0) begin
        checks++; if (got !== {32'h7FFFFFFF, 32'h80000000, 1'b1}) begin failures++; $display("FAIL sat_const got=%h exp=%h", got, {32'h7FFFFFFF, 32'h80000000, 1'b1}); end
      end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    out_ready = 1'b1;
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < LEN; i++) begin
        cur_re[i] = (f < 2) ? $urandom_range(32'h00FFFFFF) - 32'h00800000 : $urandom;
        cur_im[i] = (f < 2) ? $urandom_range(32'h00FFFFFF) - 32'h00800000 : $urandom;
      end
      send_frame(1'b1, 1'b0);
      got = {out_re, out_im, out_sat};
      checks++; if (out_valid !== 1'b1 || got !== exp_q[0]) begin failures++; $display("FAIL random_frame%0d got=%h valid=%b exp=%h", f, got, out_valid, exp_q[0]); end
      void'(exp_q.pop_front());
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_gap;
    res_t e;
    logic [N-1:0] vals [LEN];
    vals[0] = 32'h00100000; vals[1] = 32'hFFF00000; vals[2] = 32'h00300000; vals[3] = 32'h00050000;
    e = {32'h00350000, 32'h00040000, 1'b0};
    exp_q.push_back(e);
    out_ready = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_re = vals[i]; in_im = 32'h00010000;
      if (i == 1) begin
        @(negedge clk);
        in_valid = 1'b0; in_re = 32'h7FFFFFFF;
        repeat (3) @(negedge clk);
        checks++; if (frame_pos !== 2'd2) begin failures++; $display("FAIL gap_hold_pos got=%0d exp=2", frame_pos); end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    got = {out_re, out_im, out_sat};
    checks++; if (out_valid !== 1'b1 || got !== exp_q[0]) begin failures++; $display("FAIL gap_result got=%h valid=%b exp=%h", got, out_valid, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    set_const(32'h00400000, 32'h00200000); send_frame(1'b1, 1'b0);
    set_const(32'hFFC00000, 32'h00100000); send_frame(1'b1, 1'b0);
    got = {out_re, out_im, out_sat};
    checks++; if (out_valid !== 1'b1 || got !== exp_q[0]) begin failures++; $display("FAIL bp_head_f1 got=%h valid=%b exp=%h", got, out_valid, exp_q[0]); end
    @(negedge clk);
    got = {out_re, out_im, out_sat};
    checks++; if (got !== exp_q[0]) begin failures++; $display("FAIL bp_stable got=%h exp=%h", got, exp_q[0]); end
    set_const(32'h00080000, 32'h00080000); send_frame(1'b0, 1'b0);
    got = {out_re, out_im, out_sat};
    checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL bp_err_drop got=%b exp=1", err_drop); end
    checks++; if (got !== exp_q[0]) begin failures++; $display("FAIL bp_head_after_drop got=%h exp=%h", got, exp_q[0]); end
    out_ready = 1'b1;
    @(negedge clk);
    void'(exp_q.pop_front());
    got = {out_re, out_im, out_sat};
    checks++; if (out_valid !== 1'b1 || got !== exp_q[0]) begin failures++; $display("FAIL bp_head_f2 got=%h valid=%b exp=%h", got, out_valid, exp_q[0]); end
    checks++; if (got !== {32'hFF000000, 32'h00400000, 1'b0}) begin failures++; $display("FAIL bp_f2_const got=%h exp=%h", got, {32'hFF000000, 32'h00400000, 1'b0}); end
    @(negedge clk);
    void'(exp_q.pop_front());
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    checks++; if (err_drop !== 1'b1) begin failures++; $display("FAIL bp_err_sticky got=%b exp=1", err_drop); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL bp_err_clr got=%b exp=0", err_drop); end
  endtask

  task automatic test_push_pop_full;
    out_ready = 1'b0;
    set_const(32'h00010000, 32'h00020000); send_frame(1'b1, 1'b0);
    set_const(32'h00030000, 32'h00040000); send_frame(1'b1, 1'b0);
    set_const(32'h00050000, 32'h00060000); send_frame(1'b1, 1'b1);
    got = {out_re, out_im, out_sat};
    checks++; if (err_drop !== 1'b0) begin failures++; $display("FAIL ppf_err_drop got=%b exp=0", err_drop); end
    checks++; if (out_valid !== 1'b1 || got !== exp_q[0]) begin failures++; $display("FAIL ppf_head_e got=%h valid=%b exp=%h", got, out_valid, exp_q[0]); end
    out_ready = 1'b1;
    @(negedge clk);
    void'(exp_q.pop_front());
    got = {out_re, out_im, out_sat};
    checks++; if (out_valid !== 1'b1 || got !== exp_q[0]) begin failures++; $display("FAIL ppf_head_f got=%h valid=%b exp=%h", got, out_valid, exp_q[0]); end
    @(negedge clk);
    void'(exp_q.pop_front());
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ppf_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_reset_midframe;
    out_ready = 1'b0;
    set_const(32'h00400000, 32'h00400000); send_frame(1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      in_valid = 1'b1; in_re = 32'h00400000; in_im = 32'h00400000;
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (frame_pos !== 2'd2 || out_valid !== 1'b1) begin failures++; $display("FAIL rstmid_before pos=%0d valid=%b exp pos=2 valid=1", frame_pos, out_valid); end
    #2 rst = 1'b1;
    #1;
    got = {out_re, out_im, out_sat};
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%b exp=0", out_valid); end
    checks++; if (frame_pos !== 2'd0) begin failures++; $display("FAIL rstmid_pos got=%0d exp=0", frame_pos); end
    checks++; if (got !== '0) begin failures++; $display("FAIL rstmid_data got=%h exp=0", got); end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    send_frame(1'b1, 1'b0);
    got = {out_re, out_im, out_sat};
    checks++; if (out_valid !== 1'b1 || got !== {32'h01000000, 32'h01000000, 1'b0}) begin failures++; $display("FAIL rstmid_frame got=%h valid=%b exp=%h", got, out_valid, {32'h01000000, 32'h01000000, 1'b0}); end
    void'(exp_q.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_clr;
    out_ready = 1'b0;
    set_const(32'h00400000, 32'h00400000); send_frame(1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      in_valid = 1'b1; in_re = 32'h7FFFFFFF; in_im = 32'h00100000;
    end
    @(negedge clk);
    clr = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_re = 32'h12345678; in_im = 32'h0ABCDEF0;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    exp_q.delete();
    checks++; if (frame_pos !== 2'd0) begin failures++; $display("FAIL clr_pos got=%0d exp=0", frame_pos); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL clr_fifo got=%b exp=0", out_valid); end
    out_ready = 1'b1;
    set_const(32'h00400000, 32'hFFC00000); send_frame(1'b1, 1'b0);
    got = {out_re, out_im, out_sat};
    checks++; if (out_valid !== 1'b1 || got !== {32'h01000000, 32'hFF000000, 1'b0}) begin failures++; $display("FAIL clr_frame got=%h valid=%b exp=%h", got, out_valid, {32'h01000000, 32'hFF000000, 1'b0}); end
    checks++; if (got !== exp_q[0]) begin failures++; $display("FAIL clr_model got=%h exp=%h", got, exp_q[0]); end
    void'(exp_q.pop_front());
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_random();
    test_gap();
    test_backpressure();
    test_push_pop_full();
    test_reset_midframe();
    test_clr();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
